// File: rtl/mem_port_arbiter_if.sv
// Handshake and memory-port bundle shared by the arbiter and its neighbours.
// The slave side is the arbiter. The master side is the requesters plus the
// memory, as seen from a testbench or an integrating wrapper.
interface mem_port_arbiter_if #(
  parameter int WORD_SIZE = 16
);
  // core requester
  logic                 cpu_req;
  logic                 cpu_we;
  logic [WORD_SIZE-1:0] cpu_addr;
  logic [WORD_SIZE-1:0] cpu_wdata;
  logic                 cpu_gnt;
  logic                 cpu_rvalid;
  logic [WORD_SIZE-1:0] cpu_rdata;

  // cycle-stealing IO channel
  logic                 io_req;
  logic                 io_we;
  logic [WORD_SIZE-1:0] io_addr;
  logic [WORD_SIZE-1:0] io_wdata;
  logic                 io_gnt;
  logic                 io_rvalid;
  logic [WORD_SIZE-1:0] io_rdata;

  // shared memory port
  logic [WORD_SIZE-1:0] mem_add;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_data_in;
  logic [WORD_SIZE-1:0] mem_data_out;

  // debug: IO grant produced by the starvation override
  logic                 io_forced;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  io_req, io_we, io_addr, io_wdata,
    output io_gnt, io_rvalid, io_rdata,
    output mem_add, mem_write, mem_data_in,
    input  mem_data_out,
    output io_forced
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output io_req, io_we, io_addr, io_wdata,
    input  io_gnt, io_rvalid, io_rdata,
    input  mem_add, mem_write, mem_data_in,
    output mem_data_out,
    input  io_forced
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for one data-memory port.
// The core wins by default. A saturating wait counter forces an IO grant
// after MAX_WAIT consecutive losses (MAX_WAIT must lie in 1..15).
// All memory-side outputs are registered. Read data returns one edge after
// the grant, captured from a memory that samples the address on ~clk.
module mem_port_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int MAX_WAIT  = 3
) (
  input logic             clk,
  input logic             rst,
  mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

  // Which requester owns the read currently in flight in the memory.
  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CPU  = 2'd1,
    OWNER_IO   = 2'd2
  } owner_t;

  owner_t               owner_reg;
  logic [3:0]           wait_cnt_reg;
  logic                 cpu_gnt_reg;
  logic                 io_gnt_reg;
  logic                 io_forced_reg;
  logic                 cpu_rvalid_reg;
  logic                 io_rvalid_reg;
  logic [WORD_SIZE-1:0] cpu_rdata_reg;
  logic [WORD_SIZE-1:0] io_rdata_reg;
  logic [WORD_SIZE-1:0] mem_add_reg;
  logic                 mem_write_reg;
  logic [WORD_SIZE-1:0] mem_data_in_reg;

  logic                 cpu_eligible;
  logic                 io_eligible;
  logic                 force_io;
  logic                 win_cpu;
  logic                 win_io;

  // A request is consumed by its own grant cycle. This limits each requester
  // to one grant every other cycle, which leaves the alternate slot open.
  always_comb begin
    cpu_eligible = bus.cpu_req & ~cpu_gnt_reg;
    io_eligible  = bus.io_req  & ~io_gnt_reg;
    force_io     = io_eligible & (wait_cnt_reg == WAIT_LIMIT);
    win_io       = force_io | (io_eligible & ~cpu_eligible);
    win_cpu      = cpu_eligible & ~force_io;
  end

  // Arbitration, memory-port drive, read return and the fairness counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg       <= OWNER_NONE;
      wait_cnt_reg    <= '0;
      cpu_gnt_reg     <= 1'b0;
      io_gnt_reg      <= 1'b0;
      io_forced_reg   <= 1'b0;
      cpu_rvalid_reg  <= 1'b0;
      io_rvalid_reg   <= 1'b0;
      cpu_rdata_reg   <= '0;
      io_rdata_reg    <= '0;
      mem_add_reg     <= '0;
      mem_write_reg   <= 1'b0;
      mem_data_in_reg <= '0;
    end else begin
      cpu_gnt_reg   <= win_cpu;
      io_gnt_reg    <= win_io;
      io_forced_reg <= force_io;

      // Address and data hold through idle cycles. The write strobe does not,
      // so an idle cycle never repeats a write.
      if (win_cpu) begin
        mem_add_reg     <= bus.cpu_addr;
        mem_write_reg   <= bus.cpu_we;
        mem_data_in_reg <= bus.cpu_wdata;
      end else if (win_io) begin
        mem_add_reg     <= bus.io_addr;
        mem_write_reg   <= bus.io_we;
        mem_data_in_reg <= bus.io_wdata;
      end else begin
        mem_write_reg   <= 1'b0;
      end

      // The read granted on the previous edge has its data on the port now.
      cpu_rvalid_reg <= (owner_reg == OWNER_CPU);
      io_rvalid_reg  <= (owner_reg == OWNER_IO);
      if (owner_reg == OWNER_CPU) begin
        cpu_rdata_reg <= bus.mem_data_out;
      end
      if (owner_reg == OWNER_IO) begin
        io_rdata_reg <= bus.mem_data_out;
      end

      if (win_cpu && !bus.cpu_we) begin
        owner_reg <= OWNER_CPU;
      end else if (win_io && !bus.io_we) begin
        owner_reg <= OWNER_IO;
      end else begin
        owner_reg <= OWNER_NONE;
      end

      // Count only losses by a live IO request. A withdrawn request keeps
      // its accumulated credit.
      if (win_io) begin
        wait_cnt_reg <= '0;
      end else if (io_eligible && win_cpu && (wait_cnt_reg != WAIT_LIMIT)) begin
        wait_cnt_reg <= wait_cnt_reg + 4'd1;
      end
    end
  end

  assign bus.cpu_gnt     = cpu_gnt_reg;
  assign bus.io_gnt      = io_gnt_reg;
  assign bus.io_forced   = io_forced_reg;
  assign bus.cpu_rvalid  = cpu_rvalid_reg;
  assign bus.io_rvalid   = io_rvalid_reg;
  assign bus.cpu_rdata   = cpu_rdata_reg;
  assign bus.io_rdata    = io_rdata_reg;
  assign bus.mem_add     = mem_add_reg;
  assign bus.mem_write   = mem_write_reg;
  assign bus.mem_data_in = mem_data_in_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random checks for mem_port_arbiter.
// A negedge memory model sits on the port. A cycle monitor keeps per-owner
// queues of expected read data, pushed at grant and popped at rvalid.
module tb_mem_port_arbiter;
  localparam int W  = 16;
  localparam int MW = 3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  mem_port_arbiter_if #(.WORD_SIZE(W)) bus ();

  mem_port_arbiter #(.WORD_SIZE(W), .MAX_WAIT(MW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int a);
    if (a == 5) return 16'h1234;
    return 16'(a * 16'h0101) ^ 16'h5A5A;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory on the falling edge: reads the presented address, applies writes.
  logic [15:0] mem [0:255];
  bit          mem_ready;
  always @(negedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      bus.mem_data_out <= init_val(int'(bus.mem_add[7:0]));
      mem_ready <= 1'b1;
    end else begin
      if (bus.mem_write) mem[bus.mem_add[7:0]] <= bus.mem_data_in;
      bus.mem_data_out <= mem[bus.mem_add[7:0]];
    end
  end

  // Scoreboard state, owned by the monitor.
  logic [15:0] ref_mem [int];
  logic [15:0] cpu_q [$];
  logic [15:0] io_q [$];
  bit          prev_cpu_rd;
  bit          prev_io_rd;

  function automatic logic [15:0] ref_rd(input logic [15:0] a);
    if (ref_mem.exists(int'(a[7:0]))) return ref_mem[int'(a[7:0])];
    return init_val(int'(a[7:0]));
  endfunction

  // Per-cycle monitor: invariants, bus contents at grant, read return.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      cpu_q.delete();
      io_q.delete();
      prev_cpu_rd = 1'b0;
      prev_io_rd  = 1'b0;
    end else begin
      check("dual_gnt", 32'(bus.cpu_gnt & bus.io_gnt), 32'd0);
      if (bus.mem_write) check("write_outside_gnt", 32'(bus.cpu_gnt | bus.io_gnt), 32'd1);
      check("cpu_rvalid_timing", 32'(bus.cpu_rvalid), 32'(prev_cpu_rd));
      check("io_rvalid_timing", 32'(bus.io_rvalid), 32'(prev_io_rd));
      if (bus.cpu_rvalid && cpu_q.size() > 0)
        check("cpu_rdata", 32'(bus.cpu_rdata), 32'(cpu_q.pop_front()));
      if (bus.io_rvalid && io_q.size() > 0)
        check("io_rdata", 32'(bus.io_rdata), 32'(io_q.pop_front()));
      if (bus.cpu_gnt) begin
        check("cpu_mem_add", 32'(bus.mem_add), 32'(bus.cpu_addr));
        check("cpu_mem_write", 32'(bus.mem_write), 32'(bus.cpu_we));
        if (bus.cpu_we) begin
          check("cpu_mem_data_in", 32'(bus.mem_data_in), 32'(bus.cpu_wdata));
          ref_mem[int'(bus.cpu_addr[7:0])] = bus.cpu_wdata;
        end else begin
          cpu_q.push_back(ref_rd(bus.cpu_addr));
        end
      end
      if (bus.io_gnt) begin
        check("io_mem_add", 32'(bus.mem_add), 32'(bus.io_addr));
        check("io_mem_write", 32'(bus.mem_write), 32'(bus.io_we));
        if (bus.io_we) begin
          check("io_mem_data_in", 32'(bus.mem_data_in), 32'(bus.io_wdata));
          ref_mem[int'(bus.io_addr[7:0])] = bus.io_wdata;
        end else begin
          io_q.push_back(ref_rd(bus.io_addr));
        end
      end
      prev_cpu_rd = bus.cpu_gnt & ~bus.cpu_we;
      prev_io_rd  = bus.io_gnt & ~bus.io_we;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Hold one request until granted. A bounded wait counts as a miscompare.
  task automatic issue(input bit is_io, input bit we, input logic [15:0] addr, input logic [15:0] data);
    bit got;
    if (is_io) begin
      bus.io_we = we; bus.io_addr = addr; bus.io_wdata = data; bus.io_req = 1'b1;
    end else begin
      bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = data; bus.cpu_req = 1'b1;
    end
    got = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick();
      got = is_io ? bus.io_gnt : bus.cpu_gnt;
    end
    if (is_io) bus.io_req = 1'b0;
    else       bus.cpu_req = 1'b0;
    check(is_io ? "io_grant_wait" : "cpu_grant_wait", 32'(got), 32'd1);
  endtask

  initial begin
    int  cpu_wins;
    bit  got;
    n_vec = 0;
    n_err = 0;

    // Reset with both requesters pending.
    rst = 1'b1;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0001; bus.cpu_wdata = 16'h0;
    bus.io_req  = 1'b1; bus.io_we  = 1'b0; bus.io_addr  = 16'h0002; bus.io_wdata  = 16'h0;
    repeat (2) tick();
    check("rst_cpu_gnt", 32'(bus.cpu_gnt), 32'd0);
    check("rst_io_gnt", 32'(bus.io_gnt), 32'd0);
    check("rst_rvalids", 32'({bus.cpu_rvalid, bus.io_rvalid}), 32'd0);
    check("rst_rdatas", {bus.cpu_rdata, bus.io_rdata}, 32'd0);
    check("rst_mem_add", 32'(bus.mem_add), 32'd0);
    check("rst_mem_write", 32'(bus.mem_write), 32'd0);
    check("rst_mem_data_in", 32'(bus.mem_data_in), 32'd0);
    check("rst_io_forced", 32'(bus.io_forced), 32'd0);
    rst = 1'b0;
    tick();
    check("first_gnt_cpu", 32'({bus.cpu_gnt, bus.io_gnt}), 32'b10);
    bus.cpu_req = 1'b0;
    tick();
    check("second_gnt_io", 32'({bus.cpu_gnt, bus.io_gnt}), 32'b01);
    bus.io_req = 1'b0;
    repeat (2) tick();

    // Single core read of a preloaded word.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0005;
    tick();
    check("rd_gnt", 32'(bus.cpu_gnt), 32'd1);
    check("rd_mem_add", 32'(bus.mem_add), 32'h0005);
    check("rd_mem_write", 32'(bus.mem_write), 32'd0);
    bus.cpu_req = 1'b0;
    tick();
    check("rd_rvalid", 32'(bus.cpu_rvalid), 32'd1);
    check("rd_rdata", 32'(bus.cpu_rdata), 32'h1234);
    check("rd_gnt_drop", 32'(bus.cpu_gnt), 32'd0);
    tick();
    check("rd_rvalid_pulse", 32'(bus.cpu_rvalid), 32'd0);

    // IO write, then the core reads it back.
    bus.io_req = 1'b1; bus.io_we = 1'b1; bus.io_addr = 16'h00A0; bus.io_wdata = 16'hBEEF;
    tick();
    check("iow_gnt", 32'(bus.io_gnt), 32'd1);
    check("iow_mem_write", 32'(bus.mem_write), 32'd1);
    check("iow_mem_data_in", 32'(bus.mem_data_in), 32'hBEEF);
    bus.io_req = 1'b0;
    tick();
    check("iow_write_once", 32'(bus.mem_write), 32'd0);
    check("iow_no_rvalid", 32'(bus.io_rvalid), 32'd0);
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h00A0;
    tick();
    bus.cpu_req = 1'b0;
    tick();
    check("iow_readback", 32'(bus.cpu_rdata), 32'hBEEF);
    tick();

    // Both requesting continuously: strict alternation, never forced.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010;
    bus.io_req  = 1'b1; bus.io_we  = 1'b0; bus.io_addr  = 16'h0011;
    for (int k = 0; k < 8; k++) begin
      tick();
      check("alt_pattern", 32'({bus.cpu_gnt, bus.io_gnt}), (k % 2 == 0) ? 32'b10 : 32'b01);
      check("alt_not_forced", 32'(bus.io_forced), 32'd0);
    end
    bus.cpu_req = 1'b0; bus.io_req = 1'b0;
    repeat (2) tick();

    // IO present only when the core is eligible: it loses MAX_WAIT times, then is forced.
    bus.cpu_req = 1'b1; bus.io_req = 1'b1;
    cpu_wins = 0;
    got = 1'b0;
    for (int k = 0; k < 16 && !got; k++) begin
      tick();
      if (bus.io_gnt) begin
        got = 1'b1;
        check("starve_forced", 32'(bus.io_forced), 32'd1);
        check("starve_cpu_lost", 32'(bus.cpu_gnt), 32'd0);
      end else begin
        if (bus.cpu_gnt) cpu_wins++;
        bus.io_req = ~bus.cpu_gnt;
      end
    end
    bus.cpu_req = 1'b0; bus.io_req = 1'b0;
    check("starve_io_granted", 32'(got), 32'd1);
    check("starve_cpu_wins", 32'(cpu_wins), 32'(MW));
    check("starve_wait_cleared", 32'(dut.wait_cnt_reg), 32'd0);
    tick();
    check("starve_forced_pulse", 32'(bus.io_forced), 32'd0);
    tick();

    // Reset lands while a core read is in flight.
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0007;
    tick();
    check("rstrd_gnt", 32'(bus.cpu_gnt), 32'd1);
    bus.cpu_req = 1'b0;
    rst = 1'b1;
    tick();
    check("rstrd_no_rvalid", 32'(bus.cpu_rvalid), 32'd0);
    check("rstrd_rdata", 32'(bus.cpu_rdata), 32'd0);
    check("rstrd_mem_write", 32'(bus.mem_write), 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Random mixed traffic from both requesters.
    fork
      begin
        for (int n = 0; n < 50; n++) begin
          issue(1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        for (int n = 0; n < 50; n++) begin
          issue(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15)), 16'($urandom));
          repeat ($urandom_range(0, 2)) tick();
        end
      end
    join
    repeat (3) tick();
    check("cpu_reads_drained", 32'(cpu_q.size()), 32'd0);
    check("io_reads_drained", 32'(io_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time bound in case a wait escapes its cycle budget.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
